serial_adder_fsm: RTL and testbench
===================================

Name: serial_adder_fsm

Overview:
- Bit-serial multi-bit adder that sequences operands LSB-first through a single full-adder cell, one bit per clock.
- The carry is registered between bits.
- Sits directly upstream of the full-adder cell: it owns operand buffering, the carry flip-flop, bit counting and the valid/ready handshakes.
- Result is presented as a parallel word.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH)+1 (localparam), bit-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand word valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  initial carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result word.
- cout  out  1  final carry-out.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (async assert, sync deassert as seen by the FSM):
  - State = IDLE.
  - in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Operand shift regs, carry reg and counter cleared.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, load a, b, carry_q=cin, cnt=0, go to SHIFT.
  - SHIFT: each cycle, FA inputs are (a_q[0], b_q[0], carry_q).
    - FA sum is shifted into sum_q MSB-first-fill, i.e. sum_q <= {fa_sum, sum_q[WIDTH-1:1]}.
    - a_q and b_q shift right; carry_q <= fa_carry; cnt++.
    - When cnt==WIDTH-1, the final bit is processed and the FSM goes to DONE.
  - DONE: out_valid=1; sum=sum_q; cout=carry_q. On out_ready, go to IDLE.
- Latency: the accept edge is cycle k; out_valid rises after the edge at k+WIDTH, so it is visible WIDTH cycles after acceptance. Throughput is one result per WIDTH+2 cycles minimum (IDLE, WIDTH×SHIFT, DONE).
- Handshake rules:
  - in_ready=0 outside IDLE; in_valid there is ignored, with no queuing.
  - out_valid stays high and sum/cout stay stable until out_ready is sampled high.
  - out_ready outside DONE is ignored.
  - No same-cycle DONE→accept: the new operand is taken in the following IDLE cycle.
- Arithmetic: unsigned modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
  - All-ones + 1 wraps to 0 with cout=1.
- Outputs hold the last result after leaving DONE; sum/cout are only meaningful while out_valid=1.
- WIDTH=1: single SHIFT cycle, then DONE.
- Reset during SHIFT or DONE abandons the operation immediately. All outputs return to reset values and no partial result is emitted.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled at accept.
  - When sub=1, b is loaded inverted and carry_q is forced to 1 (cin ignored), giving sum = a - b mod 2^WIDTH.
  - cout = NOT borrow (1 when a>=b).
- Undefined:
  - Port sub is absent; addition only.
  - Logic is identical to the add path.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state typedef enum {IDLE, SHIFT, DONE};
  - default WIDTH constant.
- One sub-module: a single instance of the team's existing full-adder cell fulladder_usinghalfadders performs the per-bit add. The carry register stays in serial_adder_fsm.
- No other hierarchy.

Test Plan (WIDTH=8):
- Basic add: a=0x5A, b=0x33, cin=0, out_ready=1.
  - out_valid rises 8 cycles after accept.
  - sum=0x8D, cout=0; in_ready low through SHIFT/DONE.
- Wrap-around: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Backpressure: after 0x10+0x20, hold out_ready=0 for 5 cycles.
  - out_valid stays 1 and sum stays 0x30 throughout.
  - in_valid pulses are ignored.
  - Release → IDLE next cycle.
- Reset mid-operation: assert rst after 3 SHIFT cycles of 0xAA+0x55.
  - Outputs go to 0 immediately; state is IDLE.
  - Next op 0x01+0x01 gives sum=0x02, cout=0.
- Back-to-back: two consecutive ops (0x0F+0x01, 0x80+0x80) with in_valid held high → sums 0x10/cout 0, then 0x00/cout 1. Second accept occurs the cycle after DONE handshake.
- SERIAL_ADDER_SUB_EN: 0x10-0x01 → sum=0x0F, cout=1; 0x00-0x01 → sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and default operand width shared by serial_adder_fsm.
package serial_adder_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/fulladder_usinghalfadders.sv
// fulladder_usinghalfadders: one-bit full adder built from two half-adder stages.
module fulladder_usinghalfadders (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic w_s1, w_c1, w_c2;
    assign w_s1 = a ^ b;
    assign w_c1 = a & b;
    assign sum  = w_s1 ^ cin;
    assign w_c2 = w_s1 & cin;
    assign cout = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: LSB-first bit-serial adder around one full-adder cell, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via inverted b and forced carry-in).
module serial_adder_fsm
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fa_sum, w_fa_carry, w_sub;
    logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    fulladder_usinghalfadders u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_carry)
    );

    // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_next = w_fa_sum;
        end else begin : g_wn
            assign w_sum_next = {w_fa_sum, r_sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_state <= SHIFT;
            r_a     <= a;
            r_b     <= w_sub ? ~b : b;
            r_carry <= w_sub | cin;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_sum   <= w_sum_next;
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_fa_carry;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1))
                r_state <= DONE;
        end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign sum       = r_sum;
    assign cout      = r_carry;
endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb_serial_adder_fsm: randomized and directed scoreboard bench for serial_adder_fsm at WIDTH=8.
module tb_serial_adder_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    int         n_pass = 0;
    int         n_tot = 0;
    logic [8:0] q[$];
    bit         rnd_done;

    serial_adder_fsm #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Reference: plain integer arithmetic, {cout, sum}.
    function automatic logic [8:0] model(input logic [7:0] xa, xb, input logic xc, xs);
        int r;
        if (xs) return {(xa >= xb) ? 1'b1 : 1'b0, 8'(int'(xa) - int'(xb))};
        r = int'(xa) + int'(xb) + int'(xc);
        return 9'(r);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_result: sum=%0h cout=%0b with no pending op", sum, cout);
            end else begin
                logic [8:0] e;
                e = q.pop_front();
                chk("result_sum", 32'(sum), 32'(e[7:0]));
                chk("result_cout", 32'(cout), 32'(e[8]));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("wait_idle_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input logic [7:0] xa, xb, input logic xc, xs, input bit wait_out, output int lat);
        bit rdy_low = 1'b1;
        wait_idle();
        in_valid = 1'b1;
        a = xa;
        b = xb;
        cin = xc;
`ifdef SERIAL_ADDER_SUB_EN
        sub = xs;
`endif
        q.push_back(model(xa, xb, xc, xs));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        if (wait_out) begin
            while (!out_valid && lat < 50) begin
                if (in_ready || !busy) rdy_low = 1'b0;
                @(posedge clk); #1;
                lat++;
            end
            chk("in_ready_low_busy_high", 32'(rdy_low), 32'd1);
        end
    endtask

    initial begin
        int lat;
        int n;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(8'h5A, 8'h33, 1'b0, 1'b0, 1, lat);
        chk("basic_latency", 32'(lat), 32'd8);
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 1, lat);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, 1, lat);

        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    issue(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1, lat);
                    chk("rand_latency", 32'(lat), 32'd8);
                end
                rnd_done = 1'b1;
            end
            while (!rnd_done) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        join
        out_ready = 1'b1;
        wait_idle();

        out_ready = 1'b0;
        issue(8'h10, 8'h20, 1'b0, 1'b0, 1, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(sum), 32'h30);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_hold_sum", 32'(sum), 32'h30);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 32'(in_ready), 32'd1);

        issue(8'hAA, 8'h55, 1'b0, 1'b0, 0, lat);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        q.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(8'h01, 8'h01, 1'b0, 1'b0, 1, lat);
        chk("post_rst_latency", 32'(lat), 32'd8);

        wait_idle();
        in_valid = 1'b1;
        a = 8'h0F;
        b = 8'h01;
        cin = 1'b0;
        q.push_back(model(8'h0F, 8'h01, 1'b0, 1'b0));
        @(posedge clk); #1;
        chk("b2b_first_accept", 32'(busy), 32'd1);
        a = 8'h80;
        b = 8'h80;
        q.push_back(model(8'h80, 8'h80, 1'b0, 1'b0));
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_done_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("b2b_idle_gap_in_ready", 32'(in_ready), 32'd1);
        chk("b2b_idle_gap_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("b2b_second_accept", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_idle();

`ifdef SERIAL_ADDER_SUB_EN
        issue(8'h10, 8'h01, 1'b0, 1'b1, 1, lat);
        issue(8'h00, 8'h01, 1'b1, 1'b1, 1, lat);
        for (int i = 0; i < 10; i++)
            issue(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1, lat);
        sub = 1'b0;
`endif

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
